// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and its next-PC logic.
//   NPC_*     : npc_op encodings driven by decode/execute
//   BR_*      : branch_sel encodings for conditional branches
//   INST_NOP  : instruction presented when nothing real is held (addi x0,x0,0)
//   fetch_state_t : fetch FSM state encoding
package riscv_pkg;

  localparam logic [1:0] NPC_SEQ  = 2'b00;
  localparam logic [1:0] NPC_JALR = 2'b01;
  localparam logic [1:0] NPC_BR   = 2'b10;
  localparam logic [1:0] NPC_JAL  = 2'b11;

  localparam logic [1:0] BR_EQ = 2'b00;
  localparam logic [1:0] BR_NE = 2'b01;
  localparam logic [1:0] BR_LT = 2'b10;
  localparam logic [1:0] BR_GE = 2'b11;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection for the fetch stage.
// Ports:
//   i_pc, i_imm, i_alu_result : current PC, immediate, jalr target (rs1+imm)
//   i_npc_op, i_branch_sel    : resolved control from decode/execute
//   i_alu_zero, i_alu_lt      : ALU flags for branch resolution
//   o_npc                     : selected next PC
//   o_pc4                     : i_pc + 4 (also the link value)
//   o_misaligned              : o_npc is not word aligned
module npc_calc
  import riscv_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_npc_op,
  input  logic [1:0]  i_branch_sel,
  input  logic        i_alu_zero,
  input  logic        i_alu_lt,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_alu_result,
  output logic [31:0] o_npc,
  output logic [31:0] o_pc4,
  output logic        o_misaligned
);

  logic [31:0] w_pc_imm;
  logic        w_taken;

  assign o_pc4    = i_pc + 32'd4;
  assign w_pc_imm = i_pc + i_imm;

  always_comb begin
    w_taken = 1'b0;
    case (i_branch_sel)
      BR_EQ:   w_taken = i_alu_zero;
      BR_NE:   w_taken = ~i_alu_zero;
      BR_LT:   w_taken = i_alu_lt;
      BR_GE:   w_taken = ~i_alu_lt;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    o_npc = o_pc4;
    case (i_npc_op)
      NPC_SEQ:  o_npc = o_pc4;
      // jalr clears bit 0 only; bit 1 survives so a half-aligned target faults
      NPC_JALR: o_npc = i_alu_result & ~32'd1;
      NPC_BR:   o_npc = w_taken ? w_pc_imm : o_pc4;
      NPC_JAL:  o_npc = w_pc_imm;
      default:  o_npc = o_pc4;
    endcase
  end

  assign o_misaligned = |o_npc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a
// req/valid handshake, presents it to decode and steps the PC on acceptance.
// Optional fetch watchdog: define IF_TIMEOUT_EN (adds parameter TIMEOUT).
// Ports:
//   i_clk, i_rst                 : clock, async active-high reset
//   o_imem_req/o_imem_addr       : fetch request, address (= pc)
//   i_imem_rdata/i_imem_valid    : fetch response
//   o_inst_valid/o_inst/o_pc/o_pc4 : instruction presented to decode
//   i_inst_ready + npc inputs    : acceptance and resolved next-PC control
//   o_instret                    : accepted-instruction count
//   o_fault/o_fault_pc           : sticky fault and offending address
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_BOOT  | one idle cycle after reset, responses ignored
// ST_WAIT  | request outstanding at pc, waiting for imem_valid
// ST_HOLD  | instruction held for decode until inst_ready
// ST_FAULT | misaligned target or watchdog expiry, terminal until reset
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef IF_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_valid,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  input  logic        i_inst_ready,
  input  logic [1:0]  i_npc_op,
  input  logic [1:0]  i_branch_sel,
  input  logic        i_alu_zero,
  input  logic        i_alu_lt,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_alu_result,
  output logic [31:0] o_instret,
  output logic        o_fault,
  output logic [31:0] o_fault_pc
);

  fetch_state_t r_state, w_next_state;
  logic [31:0]  r_pc, r_inst, r_instret, r_fault_pc;
  logic         r_fault;
  logic [31:0]  w_npc;
  logic         w_misaligned;
  logic         w_fetch_done, w_accept, w_timeout, w_timeout_hit;

  npc_calc u_npc_calc (
    .i_pc         (r_pc),
    .i_npc_op     (i_npc_op),
    .i_branch_sel (i_branch_sel),
    .i_alu_zero   (i_alu_zero),
    .i_alu_lt     (i_alu_lt),
    .i_imm        (i_imm),
    .i_alu_result (i_alu_result),
    .o_npc        (w_npc),
    .o_pc4        (o_pc4),
    .o_misaligned (w_misaligned)
  );

`ifdef IF_TIMEOUT_EN
  logic [15:0] r_wait_cnt;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                       r_wait_cnt <= 16'd0;
    else if (r_state != ST_WAIT)     r_wait_cnt <= 16'd0;
    else if (!i_imem_valid)          r_wait_cnt <= r_wait_cnt + 16'd1;
  end

  // Fires at the end of the TIMEOUT-th WAIT cycle; valid in that cycle wins.
  assign w_timeout_hit = (r_wait_cnt == 16'(TIMEOUT - 1));
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_BOOT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_fetch_done = 1'b0;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_BOOT: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (i_imem_valid) begin
          w_fetch_done = 1'b1;
          w_next_state = ST_HOLD;
        end else if (w_timeout_hit) begin
          w_timeout    = 1'b1;
          w_next_state = ST_FAULT;
        end
      end
      ST_HOLD: begin
        if (i_inst_ready) begin
          w_accept     = 1'b1;
          w_next_state = w_misaligned ? ST_FAULT : ST_WAIT;
        end
      end
      ST_FAULT: w_next_state = ST_FAULT;
      default:  w_next_state = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_inst     <= INST_NOP;
      r_instret  <= 32'd0;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'd0;
    end else begin
      if (w_fetch_done) r_inst <= i_imem_rdata;
      if (w_accept) begin
        r_instret <= r_instret + 32'd1;
        if (w_misaligned) begin
          r_fault    <= 1'b1;
          r_fault_pc <= w_npc;
          r_inst     <= INST_NOP;
        end else begin
          r_pc <= w_npc;
        end
      end
      if (w_timeout) begin
        r_fault    <= 1'b1;
        r_fault_pc <= r_pc;
        r_inst     <= INST_NOP;
      end
    end
  end

  assign o_imem_req   = (r_state == ST_WAIT);
  assign o_imem_addr  = r_pc;
  assign o_inst_valid = (r_state == ST_HOLD);
  assign o_inst       = r_inst;
  assign o_pc         = r_pc;
  assign o_instret    = r_instret;
  assign o_fault      = r_fault;
  assign o_fault_pc   = r_fault_pc;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Holds the PC and issues word fetches to instruction memory over a req/valid handshake.
- Presents one instruction at a time to decode.
- When decode/execute accepts an instruction, it consumes the resolved control (npc_op, branch_sel, ALU flags) to compute the next PC.
- Detects misaligned targets, counts retired instructions, and has an optional fetch watchdog.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TIMEOUT, 16, max cycles in WAIT before fault (only with IF_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_req  out  1  fetch request; held high until imem_valid.
- imem_addr  out  32  fetch address; equals pc; stable while imem_req=1.
- imem_rdata  in  32  fetched word; sampled when imem_valid=1.
- imem_valid  in  1  fetch response strobe, 1 cycle.
- inst_valid  out  1  inst/pc valid to decode.
- inst  out  32  held instruction.
- pc  out  32  address of inst.
- pc4  out  32  pc+4, used for the JAL/JALR link value.
- inst_ready  in  1  decode/execute accepts inst this cycle; npc inputs valid the same cycle.
- npc_op  in  2  00 seq, 01 jalr, 10 branch, 11 jal.
- branch_sel  in  2  00 beq, 01 bne, 10 blt, 11 bge.
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  signed rs1 < rs2.
- imm  in  32  sign-extended immediate.
- alu_result  in  32  jalr target (rs1+imm).
- instret  out  32  accepted-instruction counter.
- fault  out  1  sticky fault flag.
- fault_pc  out  32  offending target/fetch address.

Behaviour:
- Reset values (async, immediate):
  - State BOOT; pc=RESET_PC.
  - imem_req=0, inst_valid=0, inst=32'h0000_0013 (NOP).
  - instret=0, fault=0, fault_pc=0.
- States: BOOT, WAIT, HOLD, FAULT.
- BOOT: outputs idle. Next cycle -> WAIT. Any imem_valid seen in BOOT is ignored.
- WAIT:
  - imem_req=1, imem_addr=pc.
  - On imem_valid: inst<=imem_rdata, inst_valid<=1 -> HOLD. Earliest inst_valid is 1 cycle after imem_valid.
- HOLD:
  - inst_valid=1; inst and pc stable.
  - imem_valid in HOLD is a protocol error and is dropped without effect.
  - On inst_ready, next-PC selection:
    - seq: npc = pc+4.
    - jal: npc = pc+imm.
    - jalr: npc = {alu_result[31:1],1'b0}.
    - branch: taken = beq:alu_zero | bne:~alu_zero | blt:alu_lt | bge:~alu_lt; npc = taken ? pc+imm : pc+4.
  - Also on inst_ready: instret<=instret+1, wrapping 32'hFFFF_FFFF->0; inst_valid<=0.
  - If npc[1:0]==0: pc<=npc -> WAIT.
  - Else: fault<=1, fault_pc<=npc, pc unchanged -> FAULT.
- FAULT: terminal until rst. imem_req=0, inst_valid=0, inst=NOP; inputs ignored.
- Arithmetic: 32-bit modulo adds; pc wraps 32'hFFFF_FFFC -> 0 on seq.
- Throughput: 1 instruction per (imem latency + 2) cycles. No speculation, no flush needed.
- Reset mid-WAIT: req drops immediately; a late imem_valid after reset release lands in BOOT and is ignored.
- inst_ready outside HOLD: ignored.

Optional Feature:
- Macro IF_TIMEOUT_EN.
- Defined:
  - 16-bit counter clears on entry to WAIT and increments each WAIT cycle without imem_valid.
  - When the counter reaches TIMEOUT: fault<=1, fault_pc<=pc -> FAULT.
  - imem_valid arriving in the same cycle wins (no fault).
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Shared package riscv_pkg holds:
  - NPC_SEQ/NPC_JALR/NPC_BR/NPC_JAL.
  - BR_EQ/BR_NE/BR_LT/BR_GE.
  - INST_NOP=32'h0000_0013.
  - fetch FSM state encoding.
- One combinational sub-module, npc_calc: pc, npc_op, branch_sel, flags, imm, alu_result -> npc, misaligned.

Test Plan:
- Reset release, RESET_PC=0, memory latency 2 -> imem_req rises the cycle after BOOT; inst_valid=1 with pc=0 the cycle after imem_valid; instret=0.
- Accept at pc=0x10, npc_op=10, branch_sel=00, alu_zero=1, imm=-8 -> next imem_addr=0x08, instret+1. Repeat with alu_zero=0 -> 0x14.
- jalr with alu_result=0x0000_0103 -> next pc=0x102 -> fault=1, fault_pc=0x102, imem_req stays 0, inst_valid=0 thereafter.
- Hold inst_ready=0 for 5 cycles in HOLD while injecting a stray imem_valid -> inst/pc unchanged, no extra request, instret unchanged.
- Assert rst in WAIT with a response due next cycle -> imem_req=0 immediately; after release the first fetch is at RESET_PC and the stale response is ignored.
- IF_TIMEOUT_EN, TIMEOUT=16, no imem_valid -> fault=1 exactly 16 WAIT cycles after entry, fault_pc=pc; imem_valid on cycle 16 -> no fault.
